cv32e40p_tb_run_ctrl: RTL and testbench
=======================================

// Module: cv32e40p_tb_run_ctrl
// PURPOSE
//  Run controller for the core testbench subsystem: sequences core reset release and
//  fetch enable, counts run cycles, and resolves completion (passed/failed/exit) into
//  one registered verdict. Sits between the bench top and the subsystem wrapper,
//  replacing ad-hoc reset/abort/exit logic. Supports back-to-back runs without global reset.
// PARAMETERS
//  RESET_HOLD_CYCLES  4   cycles core reset is held after start before release (>=1)
//  CNT_WIDTH          32  width of cycle counter and max-cycle limit
// PORTS
//  clk_i            in   1          clock
//  rst_i            in   1          synchronous active-high reset
//  start_i          in   1          start run; sampled in IDLE or DONE only
//  max_cycles_i     in   CNT_WIDTH  watchdog limit, latched on accepted start; 0 = no limit
//  tests_passed_i   in   1          subsystem passed flag
//  tests_failed_i   in   1          subsystem failed flag
//  exit_valid_i     in   1          subsystem exit strobe
//  exit_value_i     in   32         exit code, qualified by exit_valid_i
//  core_rst_no      out  1          active-low reset to subsystem rst_ni
//  fetch_enable_o   out  1          fetch enable to subsystem
//  busy_o           out  1          state is HOLD or RUN
//  done_o           out  1          verdict valid; sticky until next start or reset
//  result_o         out  2          0 none, 1 pass, 2 fail, 3 timeout
//  exit_code_o      out  32         captured exit_value_i (0 unless exit caused verdict)
//  cycle_cnt_o      out  CNT_WIDTH  RUN cycles elapsed, saturating
// BEHAVIOUR
//  - All outputs registered. On rst_i: state IDLE, core_rst_no=0, fetch_enable_o=0,
//    busy_o=0, done_o=0, result_o=0, exit_code_o=0, cycle_cnt_o=0, hold count 0.
//  - FSM IDLE -> HOLD -> RUN -> DONE; DONE -> HOLD on start_i.
//  - IDLE/DONE + start_i: next cycle HOLD; latch max_cycles_i; clear cycle_cnt_o,
//    done_o, result_o, exit_code_o; core_rst_no=0, fetch_enable_o=0.
//  - HOLD: core_rst_no=0 for exactly RESET_HOLD_CYCLES cycles, then RUN.
//  - RUN: core_rst_no=1, fetch_enable_o=1 (both rise in first RUN cycle);
//    cycle_cnt_o +1 per RUN cycle, saturates at all-ones, never wraps.
//  - Completion inputs sampled only in RUN; ignored in IDLE/HOLD/DONE.
//  - Same-cycle priority: tests_failed_i > exit_valid_i with value!=0 (fail) >
//    tests_passed_i > exit_valid_i with value==0 (pass) > timeout.
//  - exit_code_o loaded only when exit_valid_i wins; result 2 if nonzero, 1 if zero.
//  - Verdict: next cycle DONE, done_o=1, result_o set, fetch_enable_o=0,
//    core_rst_no=0 (core re-held in reset); cycle_cnt_o frozen.
//  - start_i in HOLD/RUN ignored; no abort input (use rst_i).
//  - rst_i mid-run: immediate return to reset values; no verdict produced.
// CONFIGURATION
//  - RUN_CTRL_WATCHDOG_EN defined: in RUN, when no completion input is active and
//    max_cycles_q!=0 and cycle_cnt_o==max_cycles_q, verdict timeout (result_o=3).
//  - Not defined: no timeout; max_cycles_i unused; result_o never 3; runs until an
//    input completes.
// TESTING
//  - rst_i then start_i pulse, HOLD=4 -> core_rst_no low 4 cycles, then core_rst_no
//    and fetch_enable_o high together; busy_o=1 from cycle after start.
//  - Pass: tests_passed_i pulse at RUN cycle 20 -> done_o=1, result_o=1,
//    cycle_cnt_o=20, exit_code_o=0, fetch_enable_o=0 next cycle.
//  - exit_valid_i with value 5 and tests_passed_i same cycle -> result_o=2,
//    exit_code_o=5; tests_failed_i+exit_valid_i(0) -> result_o=2, exit_code_o=0.
//  - WATCHDOG_EN, max_cycles_i=10, no completion -> result_o=3, cycle_cnt_o=10;
//    tests_passed_i on limit cycle -> result_o=1. Macro off -> no timeout after 1000.
//  - Restart from DONE via start_i -> outputs cleared, new HOLD; start_i in RUN no effect.
//  - rst_i at RUN cycle 7 -> all outputs at reset values next cycle; completion
//    pulses in IDLE/HOLD -> done_o stays 0.

Source files
------------

// File: rtl/cv32e40p_tb_run_ctrl.sv
// cv32e40p_tb_run_ctrl: run controller for the core testbench subsystem.
// Sequences core reset release and fetch enable, counts RUN cycles, and folds
// passed/failed/exit completion into one registered verdict. Runs can be
// repeated from DONE without a global reset.
// Optional feature macro: RUN_CTRL_WATCHDOG_EN (cycle-limit timeout verdict).
module cv32e40p_tb_run_ctrl #(
    parameter int unsigned RESET_HOLD_CYCLES = 4,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] max_cycles_i,
    input  logic                 tests_passed_i,
    input  logic                 tests_failed_i,
    input  logic                 exit_valid_i,
    input  logic [31:0]          exit_value_i,
    output logic                 core_rst_no,
    output logic                 fetch_enable_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           result_o,
    output logic [31:0]          exit_code_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o
);

    localparam int unsigned HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

    localparam logic [1:0] RES_NONE    = 2'd0;
    localparam logic [1:0] RES_PASS    = 2'd1;
    localparam logic [1:0] RES_FAIL    = 2'd2;
    localparam logic [1:0] RES_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_e;

    state_e               state_q, state_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           result_q, result_d;
    logic [31:0]          code_q, code_d;
    logic                 done_q, done_d;
    logic                 rstn_q, rstn_d;
    logic                 fe_q, fe_d;
    logic                 busy_q, busy_d;

    logic hold_last;
    logic accept_start;
    logic complete;
    logic fail_hit;
    logic exit_win;
    logic timeout;
    logic verdict;

    assign hold_last    = (hold_q == HW'(RESET_HOLD_CYCLES - 1));
    assign accept_start = start_i && ((state_q == IDLE) || (state_q == DONE));

    // Completion priority: failed flag, then nonzero exit, then passed flag, then zero exit.
    assign complete = tests_failed_i || tests_passed_i || exit_valid_i;
    assign fail_hit = tests_failed_i || (exit_valid_i && (exit_value_i != 32'd0));
    assign exit_win = exit_valid_i && !tests_failed_i &&
                      ((exit_value_i != 32'd0) || !tests_passed_i);

`ifdef RUN_CTRL_WATCHDOG_EN
    logic [CNT_WIDTH-1:0] maxc_q;

    // Watchdog limit is captured once per run so the bench may change the input freely.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            maxc_q <= '0;
        else if (accept_start)
            maxc_q <= max_cycles_i;
    end

    assign timeout = !complete && (maxc_q != '0) && (cnt_q == maxc_q);
`else
    logic unused_max_cycles;
    assign unused_max_cycles = ^max_cycles_i;
    assign timeout = 1'b0;
`endif

    assign verdict = complete || timeout;

    // State and registered outputs; synchronous reset returns everything to idle values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            cnt_q    <= '0;
            result_q <= RES_NONE;
            code_q   <= '0;
            done_q   <= 1'b0;
            rstn_q   <= 1'b0;
            fe_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            code_q   <= code_d;
            done_q   <= done_d;
            rstn_q   <= rstn_d;
            fe_q     <= fe_d;
            busy_q   <= busy_d;
        end
    end

    // Next-state: IDLE/DONE -> HOLD on start, HOLD -> RUN after hold time, RUN -> DONE on verdict.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_i)   state_d = HOLD;
            HOLD:       if (hold_last) state_d = RUN;
            RUN:        if (verdict)   state_d = DONE;
            default:                   state_d = IDLE;
        endcase
    end

    // Output/datapath next values; core enables follow the next state so they rise with RUN.
    always_comb begin
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        code_d   = code_q;
        done_d   = done_q;
        rstn_d   = (state_d == RUN);
        fe_d     = (state_d == RUN);
        busy_d   = (state_d == HOLD) || (state_d == RUN);
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    hold_d   = '0;
                    cnt_d    = '0;
                    result_d = RES_NONE;
                    code_d   = '0;
                    done_d   = 1'b0;
                end
            end
            HOLD: begin
                if (!hold_last)
                    hold_d = hold_q + HW'(1);
            end
            RUN: begin
                if (verdict) begin
                    // Counter freezes on the verdict cycle.
                    done_d = 1'b1;
                    if (complete)
                        result_d = (fail_hit) ? RES_FAIL : RES_PASS;
                    else
                        result_d = RES_TIMEOUT;
                    if (exit_win)
                        code_d = exit_value_i;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    assign core_rst_no    = rstn_q;
    assign fetch_enable_o = fe_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_o       = result_q;
    assign exit_code_o    = code_q;
    assign cycle_cnt_o    = cnt_q;

endmodule

// File: tb/tb_cv32e40p_tb_run_ctrl.sv
// Self-checking bench for cv32e40p_tb_run_ctrl (narrow counter so saturation is reachable).
module tb_cv32e40p_tb_run_ctrl;

    localparam int HOLD = 4;
    localparam int CW   = 8;
    localparam int SATV = (1 << CW) - 1;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i, start_i, tests_passed_i, tests_failed_i, exit_valid_i;
    logic [CW-1:0] max_cycles_i;
    logic [31:0]   exit_value_i;
    logic          core_rst_no, fetch_enable_o, busy_o, done_o;
    logic [1:0]    result_o;
    logic [31:0]   exit_code_o;
    logic [CW-1:0] cycle_cnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_tb_run_ctrl #(.RESET_HOLD_CYCLES(HOLD), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .max_cycles_i(max_cycles_i),
        .tests_passed_i(tests_passed_i), .tests_failed_i(tests_failed_i),
        .exit_valid_i(exit_valid_i), .exit_value_i(exit_value_i),
        .core_rst_no(core_rst_no), .fetch_enable_o(fetch_enable_o), .busy_o(busy_o),
        .done_o(done_o), .result_o(result_o), .exit_code_o(exit_code_o),
        .cycle_cnt_o(cycle_cnt_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_done_in();
        tests_passed_i = 1'b0;
        tests_failed_i = 1'b0;
        exit_valid_i   = 1'b0;
        exit_value_i   = '0;
    endtask

    function automatic int sat(input int i);
        return (i > SATV) ? SATV : i;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rstn"}, 64'(core_rst_no), 0);
        chk({tag, "_fe"},   64'(fetch_enable_o), 0);
        chk({tag, "_busy"}, 64'(busy_o), 0);
        chk({tag, "_done"}, 64'(done_o), 0);
        chk({tag, "_res"},  64'(result_o), 0);
        chk({tag, "_code"}, 64'(exit_code_o), 0);
        chk({tag, "_cnt"},  64'(cycle_cnt_o), 0);
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    // Pulse start, check cleared outputs, measure the core-reset hold while
    // throwing ignored completion pulses at the HOLD phase.
    task automatic do_start(input logic [CW-1:0] maxc);
        int lo;
        start_i      = 1'b1;
        max_cycles_i = maxc;
        tick();
        start_i      = 1'b0;
        max_cycles_i = CW'($urandom);
        chk("start_busy", 64'(busy_o), 1);
        chk("start_done", 64'(done_o), 0);
        chk("start_res",  64'(result_o), 0);
        chk("start_code", 64'(exit_code_o), 0);
        chk("start_cnt",  64'(cycle_cnt_o), 0);
        chk("start_fe",   64'(fetch_enable_o), 0);
        lo = 0;
        while (!core_rst_no && lo < 50) begin
            lo++;
            tests_passed_i = 1'($urandom);
            tests_failed_i = 1'($urandom);
            exit_valid_i   = 1'($urandom);
            exit_value_i   = $urandom;
            tick();
            if (!core_rst_no)
                chk("hold_done", 64'(done_o), 0);
        end
        clr_done_in();
        chk("hold_len",  64'(lo), 64'(HOLD));
        chk("run_fe",    64'(fetch_enable_o), 1);
        chk("run_busy",  64'(busy_o), 1);
        chk("run_cnt0",  64'(cycle_cnt_o), 0);
    endtask

    // One full run: completion inputs (p,f,e,v) at RUN cycle k (k<0: none),
    // optional watchdog limit maxc. Expected verdict from the rules directly.
    task automatic run_case(input int k, input logic p, input logic f, input logic e,
                            input logic [31:0] v, input logic [CW-1:0] maxc, input int limit);
        int        tcyc, exp_v, i, lim;
        logic      act;
        logic [1:0]  exp_res;
        logic [31:0] exp_code;
        logic [1:0]  keep_res;
        logic [31:0] keep_code;

        tcyc = (WD && maxc != 0) ? int'(maxc) : -1;
        act  = (k >= 0) && (p || f || e);
        exp_v = -1; exp_res = 2'd0; exp_code = '0;
        if (act && (tcyc < 0 || k <= tcyc)) begin
            exp_v = k;
            if (f || (e && v != 0))  exp_res = 2'd2;
            else                     exp_res = 2'd1;
            if (!f && e && v != 0)   exp_code = v;
        end else if (tcyc >= 0) begin
            exp_v = tcyc;
            exp_res = 2'd3;
        end
        lim = (exp_v >= 0) ? exp_v + 3 : limit;

        do_start(maxc);
        i = 0;
        while (i < lim && !done_o) begin
            if (i < 300 || i % 100 == 0)
                chk("run_cnt", 64'(cycle_cnt_o), 64'(sat(i)));
            if (i == k) begin
                tests_passed_i = p;
                tests_failed_i = f;
                exit_valid_i   = e;
                exit_value_i   = v;
            end else begin
                start_i = 1'($urandom);
            end
            tick();
            clr_done_in();
            start_i = 1'b0;
            i++;
        end

        if (exp_v >= 0) begin
            chk("vd_done",  64'(done_o), 1);
            chk("vd_cycle", 64'(i - 1), 64'(exp_v));
            chk("vd_res",   64'(result_o), 64'(exp_res));
            chk("vd_code",  64'(exit_code_o), 64'(exp_code));
            chk("vd_cnt",   64'(cycle_cnt_o), 64'(sat(exp_v)));
            chk("vd_fe",    64'(fetch_enable_o), 0);
            chk("vd_rstn",  64'(core_rst_no), 0);
            chk("vd_busy",  64'(busy_o), 0);
            // Completion inputs in DONE must not disturb the verdict.
            keep_res  = exp_res;
            keep_code = exp_code;
            tests_failed_i = 1'b1;
            exit_valid_i   = 1'b1;
            exit_value_i   = $urandom | 32'h1;
            tick();
            clr_done_in();
            chk("dn_done", 64'(done_o), 1);
            chk("dn_res",  64'(result_o), 64'(keep_res));
            chk("dn_code", 64'(exit_code_o), 64'(keep_code));
            chk("dn_cnt",  64'(cycle_cnt_o), 64'(sat(exp_v)));
        end else begin
            chk("nv_done", 64'(done_o), 0);
            chk("nv_cnt",  64'(cycle_cnt_o), 64'(sat(lim)));
            chk("nv_fe",   64'(fetch_enable_o), 1);
            apply_reset();
            check_reset_vals("nv_rst");
        end
    endtask

    initial begin
        int   k;
        logic p, f, e;
        logic [31:0] v;
        logic [CW-1:0] mc;

        rst_i = 1'b1; start_i = 1'b0; max_cycles_i = '0;
        clr_done_in();
        tick();
        tick();
        rst_i = 1'b0;
        check_reset_vals("reset");

        // Completion pulses while IDLE are ignored.
        tests_passed_i = 1'b1;
        exit_valid_i   = 1'b1;
        exit_value_i   = 32'd9;
        tick();
        clr_done_in();
        tick();
        check_reset_vals("idle_ign");

        // Directed runs.
        run_case(20, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0, 0);
        run_case(7,  1'b1, 1'b0, 1'b1, 32'd5, 8'd0, 0);
        run_case(3,  1'b0, 1'b1, 1'b1, 32'd0, 8'd0, 0);
        run_case(0,  1'b0, 1'b0, 1'b1, 32'd0, 8'd0, 0);
        if (WD) begin
            run_case(-1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd10, 0);
            run_case(10, 1'b1, 1'b0, 1'b0, 32'd0, 8'd10, 0);
        end else begin
            run_case(-1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd10, 1000);
        end

        // Reset in the middle of a run.
        do_start(8'd0);
        repeat (7) tick();
        chk("mid_cnt", 64'(cycle_cnt_o), 7);
        rst_i = 1'b1;
        tests_passed_i = 1'b1;
        tick();
        rst_i = 1'b0;
        clr_done_in();
        check_reset_vals("mid_rst");
        tick();
        chk("mid_idle_done", 64'(done_o), 0);

        // Randomized runs.
        for (int n = 0; n < 12; n++) begin
            k  = int'($urandom_range(0, 40));
            p  = 1'($urandom);
            f  = 1'($urandom);
            e  = 1'($urandom);
            v  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            mc = CW'($urandom_range(0, 30));
            run_case(k, p, f, e, v, mc, 60);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

endmodule
